// File: rtl/uart_rx_cmd_pkg.sv
// uart_rx_cmd_pkg: shared UART receive state encoding and payload width
package uart_rx_cmd_pkg;
  localparam int UART_DATA_BITS = 8;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_WAIT_HIGH} state_e;
endpackage

// File: rtl/uart_rx_cmd_if.sv
// uart_rx_cmd_if: received-byte valid/ready port (master: data/valid out, ready in; slave: mirror)
interface uart_rx_cmd_if;
  import uart_rx_cmd_pkg::*;
  logic [UART_DATA_BITS-1:0] data;
  logic                      valid;
  logic                      ready;
  modport master (output data, valid, input ready);
  modport slave (input data, valid, output ready);
endinterface

// File: rtl/uart_rx_cmd_sync2.sv
// uart_rx_cmd_sync2: 2-FF synchroniser (clk, rst_n async low, d_i async in, q_o synced out reset to RST_VAL)
module uart_rx_cmd_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic meta_q, sync_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end
  assign q_o = sync_q;
endmodule

// File: rtl/uart_rx_cmd.sv
// uart_rx_cmd: 8N1 UART receiver (clk, rst_n, rx_i serial in; out_if byte valid/ready; busy_o, frame_err_o, overrun_err_o pulses)
module uart_rx_cmd
  import uart_rx_cmd_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_i,
  uart_rx_cmd_if.master        out_if,
  output logic                 busy_o,
  output logic                 frame_err_o,
  output logic                 overrun_err_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_END  = IW'(UART_DATA_BITS - 1);
  state_e                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shreg_q, shreg_d, data_q, data_d;
  logic                      done_q, done_d, armed_q, armed_d, valid_q, valid_d;
  logic                      ferr_q, ferr_d, ovr_q, ovr_d;
  logic                      rx_s, take;
  uart_rx_cmd_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (rx_i),
    .q_o  (rx_s)
  );
  assign take = valid_q & out_if.ready;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    armed_d = armed_q | ((state_q == ST_IDLE) & rx_s);
    valid_d = valid_q & ~take;
    data_d  = data_q;
    ovr_d   = done_q & valid_q & ~take;
    if (done_q && (!valid_q || take)) begin
      data_d  = shreg_q;
      valid_d = 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = armed_q ? ST_START : ST_WAIT_HIGH;
      end
      ST_START: if (cnt_q == HALF_END) begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = rx_s ? ST_IDLE : ST_DATA;
      end
      ST_DATA: if (cnt_q == BIT_END) begin
        cnt_d   = '0;
        shreg_d = {rx_s, shreg_q[UART_DATA_BITS-1:1]};
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDX_END) state_d = ST_STOP;
      end
      ST_STOP: if (cnt_q == BIT_END) begin
        cnt_d   = '0;
        done_d  = rx_s;
        ferr_d  = ~rx_s;
        state_d = rx_s ? ST_IDLE : ST_WAIT_HIGH;
      end
      ST_WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      done_q  <= 1'b0;
      armed_q <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      done_q  <= done_d;
      armed_q <= armed_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end
  assign out_if.data   = data_q;
  assign out_if.valid  = valid_q;
  assign busy_o        = state_q != ST_IDLE;
  assign frame_err_o   = ferr_q;
  assign overrun_err_o = ovr_q;
endmodule
